wb_burst_mem_slave: RTL and testbench

// Word-addressed WISHBONE slave memory that sits directly downstream of the wb_bus

---
 rtl/wb_burst_mem_slave.sv | 209 ++++++++++++++++++++
 tb/tb_wb_burst_mem_slave.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_mem_slave
// Purpose  : Word-addressed WISHBONE slave memory with classic and
//            incrementing-burst (CTI 010) support, programmable wait states,
//            retry injection after reset and an end-of-data flag.
// Ports    : clk_i/rst_i        clock, asynchronous active-high reset
//            cyc_i/stb_i/we_i   bus cycle, strobe, write enable
//            adr_i/sel_i/cti_i  byte address, byte lanes, cycle type
//            dat_i/dat_o        write data / read data (zero unless ack_o)
//            ack_o/err_o/rty_o  registered one-cycle terminations
//            eod_o              end-of-data, only together with ack_o
// Revision : 1.0 - initial release
// ============================================================================
module wb_burst_mem_slave #(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASEADDR  = '0,
    parameter int                DEPTH     = 1024,
    parameter int                WAIT_CYC  = 1,
    parameter int                RTY_CNT   = 0,
    parameter int                EOD_BEATS = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [AWIDTH-1:0]   adr_i,
    input  logic [DWIDTH/8-1:0] sel_i,
    input  logic [2:0]          cti_i,
    input  logic [DWIDTH-1:0]   dat_i,
    output logic [DWIDTH-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                rty_o,
    output logic                eod_o
);

    localparam int                NB      = DWIDTH / 8;
    localparam int                SHIFT   = $clog2(NB);
    localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH-1:0] C_DEPTH = AWIDTH'(DEPTH);
    localparam logic [3:0]        C_WAIT  = 4'(WAIT_CYC);
    localparam logic [7:0]        C_RTY   = 8'(RTY_CNT);
    localparam logic [15:0]       C_EOD   = 16'(EOD_BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BEAT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   ptr_q, ptr_d;
    logic                below_q, below_d;      // start address was under BASEADDR
    logic                we_q, we_d;
    logic                burst_q, burst_d;
    logic [3:0]          wait_q, wait_d;
    logic [15:0]         beat_q, beat_d;
    logic [7:0]          retry_cnt_q, retry_cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rty_q, rty_d;
    logic                eod_q, eod_d;
    logic [DWIDTH-1:0]   dat_q, dat_d;

    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic [AWIDTH-1:0]   w_idx;
    logic                w_in_range;
    logic                w_last;
    logic                wr_en;

    assign w_idx      = (adr_i - BASEADDR) >> SHIFT;
    // The pointer keeps its full address width so running off the top of the
    // array during a burst is seen as out of range instead of wrapping.
    assign w_in_range = !below_q && (ptr_q < C_DEPTH);
    // A classic cycle ends after its one termination; a burst ends on CTI 111.
    assign w_last     = !burst_q || (cti_i == 3'b111);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        below_d     = below_q;
        we_d        = we_q;
        burst_d     = burst_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        retry_cnt_d = retry_cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rty_d       = 1'b0;
        eod_d       = 1'b0;
        dat_d       = '0;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    ptr_d   = w_idx;
                    below_d = (adr_i < BASEADDR);
                    we_d    = we_i;
                    burst_d = (cti_i == 3'b010);
                    beat_d  = '0;
                    wait_d  = C_WAIT;
                    state_d = (WAIT_CYC == 0) ? S_BEAT : S_WAIT;
                end
            end
            S_WAIT: begin
                // Leaving on a count of 1 makes the BEAT decision land on the
                // edge that completes the last wait state.
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (wait_q <= 4'd1) begin
                    state_d = S_BEAT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_BEAT: begin
                if (!cyc_i) begin
                    state_d = S_IDLE;
                end else if (stb_i) begin
                    if (retry_cnt_q < C_RTY) begin
                        rty_d       = 1'b1;
                        retry_cnt_d = retry_cnt_q + 8'd1;
                        state_d     = S_DONE;
                    end else if (!w_in_range) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ack_d  = 1'b1;
                        eod_d  = (C_EOD != 16'd0) && ((beat_q + 16'd1) == C_EOD);
                        beat_d = beat_q + 16'd1;
                        ptr_d  = ptr_q + AWIDTH'(1);
                        if (we_q) begin
                            wr_en = 1'b1;
                        end else begin
                            dat_d = mem_q[ptr_q[IW-1:0]];
                        end
                        if (w_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            below_q     <= 1'b0;
            we_q        <= 1'b0;
            burst_q     <= 1'b0;
            wait_q      <= '0;
            beat_q      <= '0;
            retry_cnt_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rty_q       <= 1'b0;
            eod_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            below_q     <= below_d;
            we_q        <= we_d;
            burst_q     <= burst_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            retry_cnt_q <= retry_cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rty_q       <= rty_d;
            eod_q       <= eod_d;
            dat_q       <= dat_d;
        end
    end

    // Memory contents survive reset. A write in flight when rst_i rises is
    // dropped because the state register is already forced back to IDLE.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_i[b]) begin
                    mem_q[ptr_q[IW-1:0]][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign rty_o = rty_q;
    assign eod_o = eod_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_mem_slave
// Purpose  : Self-checking bench for wb_burst_mem_slave: directed vector table,
//            hand-written retry / abort / reset sequences and random
//            transactions checked against a transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_burst_mem_slave;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          WAITC = 1;
    localparam int          RTY   = 2;
    localparam int          EOD   = 4;

    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ERR  = 2;
    localparam int K_RTY  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [AW-1:0] adr_i = '0;
    logic [3:0]    sel_i = '0;
    logic [2:0]    cti_i = '0;
    logic [DW-1:0] dat_i = '0;
    logic [DW-1:0] dat_o;
    logic          ack_o, err_o, rty_o, eod_o;

    wb_burst_mem_slave #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .BASEADDR (BASE),
        .DEPTH    (DEPTH),
        .WAIT_CYC (WAITC),
        .RTY_CNT  (RTY),
        .EOD_BEATS(EOD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .sel_i(sel_i), .cti_i(cti_i), .dat_i(dat_i),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .eod_o(eod_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: memory, masks of known bits, retries
    logic [31:0] m_mem  [DEPTH];
    logic [31:0] m_mask [DEPTH];
    int          m_rty;
    int          e_nterm;
    int          e_kind [8];
    logic [31:0] e_dat  [8];
    logic [31:0] e_mask [8];
    bit          e_eod  [8];

    task automatic model_txn(input logic [31:0] adr, input int nb, input bit we,
                             input logic [3:0] sel, input logic [31:0] wd);
        longint      idx;
        int          w;
        logic [31:0] d;
        e_nterm = 0;
        for (int k = 0; k < 8; k++) begin
            e_kind[k] = K_NONE; e_dat[k] = '0; e_mask[k] = '0; e_eod[k] = 1'b0;
        end
        if (m_rty > 0) begin
            m_rty--;
            e_kind[0] = K_RTY;
            e_nterm   = 1;
            return;
        end
        idx = (adr < BASE) ? -1 : longint'((adr - BASE) >> 2);
        for (int k = 0; k < nb; k++) begin
            e_nterm = k + 1;
            if (idx < 0 || idx + k >= DEPTH) begin
                e_kind[k] = K_ERR;
                return;
            end
            w         = int'(idx) + k;
            e_kind[k] = K_ACK;
            e_eod[k]  = (EOD != 0) && (k + 1 == EOD);
            if (we) begin
                d = wd + 32'(k);
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) begin
                        m_mem[w][8*b +: 8]  = d[8*b +: 8];
                        m_mask[w][8*b +: 8] = 8'hFF;
                    end
                end
            end else begin
                e_dat[k]  = m_mem[w];
                e_mask[k] = m_mask[w];
            end
        end
    endtask

    // ---------------- bus master: one transaction, observations into t_*
    int          t_nterm, t_first, t_cycles, t_gaps;
    bit          t_bad, t_timeout;
    int          t_kind [8];
    logic [31:0] t_dat  [8];
    bit          t_eod  [8];

    task automatic run_burst(input logic [31:0] adr, input int nb, input bit we, input bit burst,
                             input logic [3:0] sel, input logic [31:0] wd, input int gap);
        int k, n;
        t_nterm = 0; t_first = 0; t_gaps = 0; t_bad = 0; t_timeout = 0; n = 0; k = 0;
        for (int i = 0; i < 8; i++) begin
            t_kind[i] = K_NONE; t_dat[i] = '0; t_eod[i] = 1'b0;
        end
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = wd;
        cti_i = burst ? ((nb == 1) ? 3'b111 : 3'b010) : 3'b000;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (n > 40) begin
                t_timeout = 1'b1;
                break;
            end
            if ((32'(ack_o) + 32'(err_o) + 32'(rty_o)) > 1) t_bad = 1'b1;
            if (eod_o && !ack_o) t_bad = 1'b1;
            if (ack_o || err_o || rty_o) begin
                if (t_nterm == 0) t_first = n;
                t_kind[t_nterm] = ack_o ? K_ACK : (err_o ? K_ERR : K_RTY);
                t_dat[t_nterm]  = dat_o;
                t_eod[t_nterm]  = eod_o;
                t_nterm++;
                if (!ack_o || t_nterm == nb || !burst) break;
                k++;
                adr_i = adr_i + 32'd4;
                dat_i = wd + 32'(k);
                cti_i = (k == nb - 1) ? 3'b111 : 3'b010;
                if (k == gap) begin
                    stb_i = 1'b0;
                    @(posedge clk); #1;
                    n++; t_gaps++;
                    if (ack_o || err_o || rty_o || dat_o != 0) t_bad = 1'b1;
                    stb_i = 1'b1;
                end
            end else if (dat_o != 0) begin
                t_bad = 1'b1;
            end
        end
        t_cycles = n;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack_o || err_o || rty_o || eod_o || dat_o != 0) t_bad = 1'b1;
        end
    endtask

    task automatic check_txn(input string tag, input logic [31:0] adr, input int nb_in, input bit we,
                             input bit burst, input logic [3:0] sel, input logic [31:0] wd, input int gap);
        int nb;
        nb = burst ? nb_in : 1;
        model_txn(adr, nb, we, sel, wd);
        run_burst(adr, nb, we, burst, sel, wd, gap);
        chk({tag, " timeout"}, 32'(t_timeout), 32'd0);
        chk({tag, " nterm"}, t_nterm, e_nterm);
        for (int k = 0; k < e_nterm; k++) begin
            chk($sformatf("%s kind[%0d]", tag, k), t_kind[k], e_kind[k]);
            chk($sformatf("%s eod[%0d]", tag, k), 32'(t_eod[k]), 32'(e_eod[k]));
            if (!we && e_kind[k] == K_ACK && e_mask[k] != 0)
                chk($sformatf("%s rdata[%0d]", tag, k), t_dat[k] & e_mask[k], e_dat[k] & e_mask[k]);
        end
        chk({tag, " first_lat"}, t_first, 2 + WAITC);
        chk({tag, " cycles"}, t_cycles, (2 + WAITC) + (e_nterm - 1) + t_gaps);
        chk({tag, " clean"}, 32'(t_bad), 32'd0);
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic [31:0] adr;
        int          nb;
        bit          we;
        bit          burst;
        logic [3:0]  sel;
        logic [31:0] wd;
        int          gap;
        int          exp_acks;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd0;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, n, w, nb, gap;
        bit bad, burst;
        logic [31:0] adr;

        tbl[0]  = '{32'h1000, 1, 1'b1, 1'b0, 4'hF, 32'h0BAD_F00D, 0, 1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{32'h1004, 1, 1'b1, 1'b0, 4'hF, 32'hA5A5_5A5A, 0, 1, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{32'h1004, 1, 1'b0, 1'b0, 4'hF, 32'h0,         0, 1, 1'b0, 1'b1, 32'hA5A5_5A5A};
        tbl[3]  = '{32'h1008, 1, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF, 0, 1, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{32'h1008, 1, 1'b1, 1'b0, 4'h2, 32'h1122_3344, 0, 1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{32'h1008, 1, 1'b0, 1'b0, 4'hF, 32'h0,         0, 1, 1'b0, 1'b1, 32'hFFFF_33FF};
        tbl[6]  = '{32'h1020, 4, 1'b1, 1'b1, 4'hF, 32'h8000_0000, 0, 4, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{32'h1020, 4, 1'b0, 1'b1, 4'hF, 32'h0,         0, 4, 1'b0, 1'b1, 32'h8000_0000};
        tbl[8]  = '{32'h1100, 1, 1'b1, 1'b0, 4'hF, 32'hDEAD_BEEF, 0, 0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{32'h1000, 1, 1'b0, 1'b0, 4'hF, 32'h0,         0, 1, 1'b0, 1'b1, 32'h0BAD_F00D};
        tbl[10] = '{32'h0FFC, 1, 1'b0, 1'b0, 4'hF, 32'h0,         0, 0, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{32'h10F8, 4, 1'b1, 1'b1, 4'hF, 32'h6200_0000, 0, 2, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{32'h10F8, 4, 1'b0, 1'b1, 4'hF, 32'h0,         0, 2, 1'b1, 1'b1, 32'h6200_0000};
        tbl[13] = '{32'h1020, 4, 1'b0, 1'b1, 4'hF, 32'h0,         2, 4, 1'b0, 1'b1, 32'h8000_0000};

        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0; m_mask[i] = '0;
        end
        m_rty = RTY;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", 32'(ack_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset rty", 32'(rty_o), 32'd0);
        chk("reset eod", 32'(eod_o), 32'd0);
        chk("reset dat", dat_o, 32'd0);
        rst = 1'b0;

        // Retry injection: three classic reads -> rty, rty, ack
        for (int i = 0; i < 3; i++) begin
            check_txn($sformatf("retry%0d", i), BASE + 32'd4, 1, 1'b0, 1'b0, 4'hF, 32'h0, 0);
            chk($sformatf("retry%0d term", i), t_kind[0], (i < 2) ? K_RTY : K_ACK);
        end

        // cyc_i dropped while waiting: no termination, next access served
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE; sel_i = 4'hF; cti_i = 3'b000;
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack_o || err_o || rty_o) bad = 1'b1;
        end
        chk("wait_abort no_term", 32'(bad), 32'd0);
        check_txn("after_abort", BASE + 32'd12, 1, 1'b1, 1'b0, 4'hF, 32'h1357_9BDF, 0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            check_txn($sformatf("vec%0d", i), tbl[i].adr, tbl[i].nb, tbl[i].we, tbl[i].burst,
                      tbl[i].sel, tbl[i].wd, tbl[i].gap);
            acks = 0;
            for (int k = 0; k < t_nterm; k++) if (t_kind[k] == K_ACK) acks++;
            chk($sformatf("vec%0d acks", i), acks, tbl[i].exp_acks);
            chk($sformatf("vec%0d err", i),
                32'(t_nterm > 0 && t_kind[t_nterm-1] == K_ERR), 32'(tbl[i].exp_err));
            if (tbl[i].chk_rd) chk($sformatf("vec%0d rd0", i), t_dat[0], tbl[i].exp_rd0);
        end

        // Random transactions against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       w = -1;
                1, 2:    w = DEPTH - 3 + int'($urandom_range(0, 4));
                default: w = int'($urandom_range(0, 15));
            endcase
            adr   = BASE + 32'(w * 4);
            nb    = int'($urandom_range(1, 6));
            burst = (nb > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            gap   = (nb > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb - 1)) : 0;
            check_txn($sformatf("rnd%0d", i), adr, nb, 1'($urandom_range(0, 1)), burst,
                      4'($urandom_range(1, 15)), $urandom, gap);
        end

        // Reset during beat 2 of a write burst
        check_txn("rst_preload", BASE + 32'd80, 4, 1'b1, 1'b1, 4'hF, 32'h2000_0000, 0);
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = BASE + 32'd80; sel_i = 4'hF;
        dat_i = 32'hDEAD_0000; cti_i = 3'b010;
        n = 0;
        while (!ack_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_burst first_ack", 32'(ack_o), 32'd1);
        m_mem[20] = 32'hDEAD_0000;
        m_mask[20] = 32'hFFFF_FFFF;
        adr_i = adr_i + 32'd4;
        dat_i = 32'hDEAD_0001;
        #1 rst = 1'b1;
        #1;
        chk("rst_async ack", 32'(ack_o), 32'd0);
        chk("rst_async err", 32'(err_o), 32'd0);
        chk("rst_async rty", 32'(rty_o), 32'd0);
        chk("rst_async eod", 32'(eod_o), 32'd0);
        chk("rst_async dat", dat_o, 32'd0);
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rty = RTY;
        for (int i = 0; i < 3; i++)
            check_txn($sformatf("post_rst%0d", i), BASE + 32'd80, 2, 1'b0, 1'b1, 4'hF, 32'h0, 0);
        chk("post_rst word21", t_dat[1], 32'h2000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
